// File: rtl/serial_add.sv
// Bit-serial adder/subtractor: one full adder plus a carry flop, LSB first,
// one result bit per clock, valid/ready handshake on both sides.

module add1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic out,
  output logic carry_out
);
  assign out       = a ^ b ^ cin;
  assign carry_out = (a & b) | (cin & (a ^ b));
endmodule

module serial_add #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             sum_bit_s;
  logic             carry_bit_s;

  add1 u_add1 (
    .a         (a_q[cnt_q]),
    .b         (b_q[cnt_q]),
    .cin       (carry_q),
    .out       (sum_bit_s),
    .carry_out (carry_bit_s)
  );

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    res_d       = res_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction as A + ~B + 1: the +1 enters through the carry flop.
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub;
          cnt_d      = {CW{1'b0}};
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        res_d[cnt_q] = sum_bit_s;
        carry_d      = carry_bit_s;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB.
          cout_d      = carry_bit_s;
          ovf_d       = carry_q ^ carry_bit_s;
          zero_d      = (res_d == {WIDTH{1'b0}});
          cnt_d       = {CW{1'b0}};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      carry_q     <= 1'b0;
      res_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_serial_add.sv
// Directed and exhaustive checks of serial_add (WIDTH=4) with per-scenario tasks.
`timescale 1ns/1ps

module tb_serial_add;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int checks;
  int errors;

  serial_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and hold it until an edge with in_ready=1 accepts it.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, output bit ok);
    ok       = 1'b0;
    a        = ta;
    b        = tb;
    sub      = tsub;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      edges++;
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, result, carry_out, overflow, zero} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b res=%h c=%b v=%b z=%b expected rdy=1 vld=0 res=0 c=0 v=0 z=0",
               in_ready, out_valid, result, carry_out, overflow, zero);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    bit ok;
    int e;
    start_op(4'd7, 4'd1, 1'b0, ok);
    a = 4'd0; b = 4'd0;
    wait_done(e);
    checks++;
    if (!ok || e !== 4) begin
      errors++;
      $display("FAIL add_7_1_latency: accepted=%0d edges=%0d expected 4", ok, e);
    end
    checks++;
    if ({result, carry_out, overflow, zero} !== {4'd8, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_7_1: got res=%0d c=%b v=%b z=%b expected res=8 c=0 v=1 z=0",
               result, carry_out, overflow, zero);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_release: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
    end
    start_op(4'd15, 4'd1, 1'b0, ok);
    wait_done(e);
    checks++;
    if (!ok || e !== 4 || {result, carry_out, overflow, zero} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_15_1: edges=%0d res=%0d c=%b v=%b z=%b expected edges=4 res=0 c=1 v=0 z=1",
               e, result, carry_out, overflow, zero);
    end
  endtask

  task automatic test_sub();
    bit ok;
    int e;
    start_op(4'd3, 4'd5, 1'b1, ok);
    wait_done(e);
    checks++;
    if (!ok || e !== 4 || {result, carry_out, overflow, zero} !== {4'd14, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_3_5: edges=%0d res=%0d c=%b v=%b z=%b expected edges=4 res=14 c=0 v=0 z=0",
               e, result, carry_out, overflow, zero);
    end
    start_op(4'd8, 4'd1, 1'b1, ok);
    sub = 1'b0;
    wait_done(e);
    checks++;
    if (!ok || e !== 4 || {result, carry_out, overflow, zero} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_8_1: edges=%0d res=%0d c=%b v=%b z=%b expected edges=4 res=7 c=1 v=1 z=0",
               e, result, carry_out, overflow, zero);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int e;
    out_ready = 1'b0;
    start_op(4'd7, 4'd8, 1'b0, ok);
    wait_done(e);
    checks++;
    if (!ok || e !== 4) begin
      errors++;
      $display("FAIL bp_latency: edges=%0d expected 4", e);
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      a = 4'(i + 1);
      b = 4'(i + 3);
      sub = i[0];
      tick();
      checks++;
      if ({out_valid, in_ready, result, carry_out, overflow} !== {1'b1, 1'b0, 4'd15, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%0d c=%b v=%b expected vld=1 rdy=0 res=15 c=0 v=0",
                 i, out_valid, in_ready, result, carry_out, overflow);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_queue: vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int e;
    start_op(4'd9, 4'd9, 1'b0, ok);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_valid, result, carry_out, overflow, zero} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b res=%0d c=%b v=%b z=%b expected rdy=1 vld=0 res=0 c=0 v=0 z=0",
               in_ready, out_valid, result, carry_out, overflow, zero);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL reset_mid_pulse: vld=%b expected 0 at cycle %0d", out_valid, i);
      end
    end
    start_op(4'd2, 4'd2, 1'b0, ok);
    wait_done(e);
    checks++;
    if (!ok || e !== 4 || result !== 4'd4 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: edges=%0d res=%0d z=%b expected edges=4 res=4 z=0", e, result, zero);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int e;
    logic [4:0] full;
    logic [3:0] er;
    logic ec, ev, ez;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          full = (s == 1) ? ({1'b0, 4'(x)} + {1'b0, ~4'(y)} + 5'd1)
                          : ({1'b0, 4'(x)} + {1'b0, 4'(y)});
          er = full[3:0];
          ec = full[4];
          ez = (er == 4'd0);
          if (s == 1) ev = (x[3] != y[3]) && (er[3] != x[3]);
          else        ev = (x[3] == y[3]) && (er[3] != x[3]);
          start_op(4'(x), 4'(y), s[0], ok);
          a   = ~4'(x);
          b   = 4'(y + 5);
          sub = ~s[0];
          wait_done(e);
          checks++;
          if (!ok || e !== 4) begin
            errors++;
            $display("FAIL sweep_latency a=%0d b=%0d sub=%0d: accepted=%0d edges=%0d expected 4",
                     x, y, s, ok, e);
          end
          checks++;
          if ({result, carry_out, overflow, zero} !== {er, ec, ev, ez}) begin
            errors++;
            $display("FAIL sweep a=%0d b=%0d sub=%0d: got res=%0d c=%b v=%b z=%b expected res=%0d c=%b v=%b z=%b",
                     x, y, s, result, carry_out, overflow, zero, er, ec, ev, ez);
          end
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    sub       = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
